// File: rtl/game_tick_controller_pkg.sv
// Shared definitions for the Endless Wave game-flow controller.
//   state_t   : game-flow state encoding, also driven out on the state port
//   STATE_W   : width of the state encoding
//   LEVEL_MAX : saturation value of the level counter
package game_tick_controller_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [3:0] LEVEL_MAX = 4'd15;

endpackage

// File: rtl/game_tick_controller_rise_detect.sv
// Rising-edge detector for an already-synchronised button level.
//   clock : system clock
//   reset : synchronous, active-high
//   in    : button level
//   rise  : in & ~previous sample (combinational, valid for the current clock)
// The previous-sample register resets to 1, so a button already held down
// while reset releases does not produce a spurious edge.
module game_tick_controller_rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic prev;

  always_ff @(posedge clock) begin
    if (reset) prev <= 1'b1;
    else       prev <= in;
  end

  assign rise = in & ~prev;

endmodule

// File: rtl/game_tick_controller.sv
// Game-flow FSM and variable-rate tick generator for Endless Wave.
//   clock         : system clock
//   reset         : synchronous, active-high
//   start         : start/restart button level, rising edge acts
//   pause         : pause button level, rising edge toggles RUN<->PAUSE
//   collision     : player hit level, only looked at in RUN
//   game_tick     : one-clock pulse per tick period, only in RUN
//   score_enable  : 1 while in RUN
//   score_reset_n : active-low one-clock clear for the score counter
//   level         : difficulty level, saturates at 15
//   state         : IDLE=0, RUN=1, PAUSE=2, OVER=3
//   game_over     : 1 while in OVER
// Every LEVEL_TICKS ticks the tick period shrinks by TICK_DIV_STEP down to
// TICK_DIV_MIN. Requires TICK_DIV_MIN >= 2 so ticks are never back to back.
module game_tick_controller
  import game_tick_controller_pkg::*;
#(
  parameter int DIV_W         = 26,
  parameter int TICK_DIV_INIT = 25_000_000,
  parameter int TICK_DIV_MIN  = 2_500_000,
  parameter int TICK_DIV_STEP = 1_250_000,
  parameter int LEVEL_TICKS   = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         pause,
  input  logic         collision,
  output logic         game_tick,
  output logic         score_enable,
  output logic         score_reset_n,
  output logic [3:0]   level,
  output logic [STATE_W-1:0] state,
  output logic         game_over
);

  localparam int CNT_W = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEVEL_TICKS - 1);
  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(TICK_DIV_INIT);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(TICK_DIV_MIN);
  localparam logic [DIV_W-1:0] DIV_STEP = DIV_W'(TICK_DIV_STEP);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  // Period after a level-up; the subtraction carries an extra bit so a step
  // larger than the current period clamps to the floor instead of wrapping.
  function automatic logic [DIV_W-1:0] ramp_period(input logic [DIV_W-1:0] p);
    logic [DIV_W:0] diff;
    diff = {1'b0, p} - {1'b0, DIV_STEP};
    if (diff[DIV_W] || (diff[DIV_W-1:0] < DIV_MIN)) return DIV_MIN;
    else                                             return diff[DIV_W-1:0];
  endfunction

  function automatic logic [3:0] sat_level(input logic [3:0] l);
    return (l == LEVEL_MAX) ? l : l + 4'd1;
  endfunction

  state_t             st;
  logic [DIV_W-1:0]   period;
  logic [DIV_W-1:0]   divider;
  logic [DIV_W-1:0]   next_period;
  logic [CNT_W-1:0]   tick_cnt;
  logic               start_rise;
  logic               pause_rise;

  game_tick_controller_rise_detect u_start_rise (
    .clock (clock),
    .reset (reset),
    .in    (start),
    .rise  (start_rise)
  );

  game_tick_controller_rise_detect u_pause_rise (
    .clock (clock),
    .reset (reset),
    .in    (pause),
    .rise  (pause_rise)
  );

  always_comb next_period = ramp_period(period);

  assign state = st;

  always_ff @(posedge clock) begin
    if (reset) begin
      st            <= ST_IDLE;
      level         <= 4'd0;
      period        <= DIV_INIT;
      divider       <= DIV_INIT - DIV_ONE;
      tick_cnt      <= '0;
      game_tick     <= 1'b0;
      score_enable  <= 1'b0;
      score_reset_n <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      game_tick     <= 1'b0;
      score_reset_n <= 1'b1;
      case (st)
        ST_IDLE: begin
          if (start_rise) begin
            // Clear is registered, so it lands on the same edge RUN begins.
            st            <= ST_RUN;
            divider       <= period - DIV_ONE;
            score_reset_n <= 1'b0;
            score_enable  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (collision) begin
            st           <= ST_OVER;
            score_enable <= 1'b0;
            game_over    <= 1'b1;
          end else if (pause_rise) begin
            st           <= ST_PAUSE;
            score_enable <= 1'b0;
          end else if (divider == '0) begin
            game_tick <= 1'b1;
            if (tick_cnt == CNT_LAST) begin
              // The shorter period already governs the interval that starts now.
              tick_cnt <= '0;
              level    <= sat_level(level);
              period   <= next_period;
              divider  <= next_period - DIV_ONE;
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
              divider  <= period - DIV_ONE;
            end
          end else begin
            divider <= divider - DIV_ONE;
          end
        end
        ST_PAUSE: begin
          // Divider is held; start and collision have no effect here.
          if (pause_rise) begin
            st           <= ST_RUN;
            score_enable <= 1'b1;
          end
        end
        ST_OVER: begin
          // Score stays visible; it is cleared on the next IDLE->RUN start.
          if (start_rise) begin
            st        <= ST_IDLE;
            game_over <= 1'b0;
            period    <= DIV_INIT;
            level     <= 4'd0;
            tick_cnt  <= '0;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_tick_controller.sv
module tb_game_tick_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       pause;
  logic       collision;
  logic       game_tick;
  logic       score_enable;
  logic       score_reset_n;
  logic [3:0] level;
  logic [1:0] state;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  game_tick_controller #(
    .DIV_W         (26),
    .TICK_DIV_INIT (8),
    .TICK_DIV_MIN  (2),
    .TICK_DIV_STEP (2),
    .LEVEL_TICKS   (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .pause         (pause),
    .collision     (collision),
    .game_tick     (game_tick),
    .score_enable  (score_enable),
    .score_reset_n (score_reset_n),
    .level         (level),
    .state         (state),
    .game_over     (game_over)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Clocks until game_tick is seen high; limit+1 if it never comes.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!game_tick && n <= 100);
  endtask

  initial begin
    int n;
    int ticks;
    int bad;

    reset = 1'b1; start = 1'b0; pause = 1'b0; collision = 1'b0;
    step(); step(); step();

    // 1: reset state, start, first tick latency
    check("rst_state", state, 0);
    check("rst_level", level, 0);
    check("rst_tick", game_tick, 0);
    check("rst_en", score_enable, 0);
    check("rst_clr", score_reset_n, 0);
    check("rst_over", game_over, 0);
    reset = 1'b0;
    step();
    check("clr_release", score_reset_n, 1);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_state", state, 1);
    check("start_clr", score_reset_n, 0);
    check("start_en", score_enable, 1);
    step();
    check("clr_one_clk", score_reset_n, 1);
    wait_tick(n);
    check("first_tick_lat", n, 7);  // one clock already spent above
    wait_tick(n);
    check("second_tick_int", n, 8);

    // 3: pause while divider holds 3
    step(); step(); step(); step();
    pause = 1'b1;
    step();
    check("pause_state", state, 2);
    check("pause_en", score_enable, 0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (game_tick) ticks++;
    end
    check("pause_no_tick", ticks, 0);
    check("pause_hold_state", state, 2);
    pause = 1'b0;
    step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    check("resume_state", state, 1);
    ticks = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (game_tick) ticks++;
    end
    check("resume_early_tick", ticks, 0);
    step();
    check("resume_tick", game_tick, 1);

    // 2: difficulty ramp
    wait_tick(n);
    check("lvl0_int", n, 8);
    check("lvl1", level, 1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      if (n != 6) bad++;
    end
    check("lvl1_int6_bad", bad, 0);
    check("lvl2", level, 2);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      if (n != 4) bad++;
    end
    check("lvl2_int4_bad", bad, 0);
    check("lvl3", level, 3);
    bad = 0;
    for (int i = 0; i < 52; i++) begin
      wait_tick(n);
      if (n != 2) bad++;
    end
    check("floor_int2_bad", bad, 0);
    check("level_sat", level, 15);

    // 4: collision on the divider==0 clock
    step();
    collision = 1'b1;
    step();
    collision = 1'b0;
    check("coll_state", state, 3);
    check("coll_no_tick", game_tick, 0);
    check("coll_en", score_enable, 0);
    check("coll_over", game_over, 1);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("over_idle", state, 0);
    check("over_level", level, 0);
    check("over_flag", game_over, 0);

    // 5: start held through reset release
    start = 1'b1;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    check("held_clr", score_reset_n, 1);
    step(); step();
    check("held_state", state, 0);
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("press_state", state, 1);
    check("press_clr", score_reset_n, 0);

    // 6: reset mid-RUN at level 2
    wait_tick(n);
    check("restart_lat", n, 8);
    for (int i = 0; i < 7; i++) wait_tick(n);
    check("mid_level", level, 2);
    step(); step(); step();
    reset = 1'b1;
    step();
    check("mrst_state", state, 0);
    check("mrst_level", level, 0);
    check("mrst_tick", game_tick, 0);
    check("mrst_en", score_enable, 0);
    check("mrst_clr", score_reset_n, 0);
    check("mrst_over", game_over, 0);
    step();
    reset = 1'b0;
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (game_tick) ticks++;
    end
    check("mrst_no_tick", ticks, 0);
    check("mrst_idle", state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
